// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and defaults for the next-PC / stall controller.
//   state_e     : controller FSM states
//   PC_W_DEF    : default PC width in bits
//   PC_STEP_DEF : default sequential PC increment
package pc_seq_pkg;

  localparam int PC_W_DEF    = 8;
  localparam int PC_STEP_DEF = 4;

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_RUN     = 3'd1,
    ST_LDSTALL = 3'd2,
    ST_MEMWAIT = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// pc_seq_ctrl_if: pipeline-side signals of the next-PC / stall controller.
//   master : pipeline (drives pc, ID/EX info, branch, halt, resume, mem_busy)
//   slave  : controller (drives npc, wpcir, flush, bubble, halted, stall_cnt)
interface pc_seq_ctrl_if
  import pc_seq_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);

  logic [PC_W-1:0] pc;
  logic [4:0]      id_rs;
  logic [4:0]      id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            ex_m2reg;
  logic            ex_wreg;
  logic [4:0]      ex_rn;
  logic            id_br_taken;
  logic [PC_W-1:0] id_target;
  logic            id_halt;
  logic            resume;
  logic            mem_busy;

  logic [PC_W-1:0] npc;
  logic            wpcir;
  logic            flush;
  logic            bubble;
  logic            halted;
  logic [15:0]     stall_cnt;

  modport master (
    output pc, id_rs, id_rt, id_use_rs, id_use_rt, ex_m2reg, ex_wreg, ex_rn,
           id_br_taken, id_target, id_halt, resume, mem_busy,
    input  npc, wpcir, flush, bubble, halted, stall_cnt
  );

  modport slave (
    input  pc, id_rs, id_rt, id_use_rs, id_use_rt, ex_m2reg, ex_wreg, ex_rn,
           id_br_taken, id_target, id_halt, resume, mem_busy,
    output npc, wpcir, flush, bubble, halted, stall_cnt
  );

endinterface

// File: rtl/pc_seq_hazard.sv
// pc_seq_hazard: combinational load-use hazard detection.
//   ex_m2reg_i, ex_wreg_i, ex_rn_i : EX-stage load / write / destination
//   id_rs_i, id_rt_i               : ID-stage source registers
//   id_use_rs_i, id_use_rt_i       : ID instruction actually reads rs / rt
//   hazard_o                       : ID must wait for the load result
module pc_seq_hazard (
  input  logic       ex_m2reg_i,
  input  logic       ex_wreg_i,
  input  logic [4:0] ex_rn_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_use_rs_i,
  input  logic       id_use_rt_i,
  output logic       hazard_o
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign hazard_o = ex_m2reg_i & ex_wreg_i & (ex_rn_i != 5'd0) &
                    ((id_use_rs_i & (ex_rn_i == id_rs_i)) |
                     (id_use_rt_i & (ex_rn_i == id_rt_i)));

endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC and stall controller for the 8-bit pipelined CPU.
//   clk, rst_n : clock, asynchronous active-low reset
//   ctl        : pc_seq_ctrl_if.slave (pipeline inputs, npc/wpcir/flush/
//                bubble/halted/stall_cnt outputs)
// Optional feature macro PC_SEQ_PERF_EN: saturating stall-cycle counter on
// stall_cnt; when undefined stall_cnt is tied to zero.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_BOOT    | first cycle after reset, NOP into IF/ID, PC forced to 0
// ST_RUN     | normal fetch; resolves mem stall, halt, load-use, branch
// ST_LDSTALL | extra load-use bubbles, ld_cnt counts down to 1
// ST_MEMWAIT | data memory busy, whole pipe frozen
// ST_HALT    | HALT in ID, waits for resume pulse
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int PC_STEP  = PC_STEP_DEF,
  parameter int LD_STALL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_seq_ctrl_if.slave  ctl
);

  state_e          state_q, state_d;
  logic [1:0]      ld_cnt_q, ld_cnt_d;
  logic            hazard;
  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] npc_c;
  logic            wpcir_c, flush_c, bubble_c, halted_c;

  pc_seq_hazard u_hazard (
    .ex_m2reg_i  (ctl.ex_m2reg),
    .ex_wreg_i   (ctl.ex_wreg),
    .ex_rn_i     (ctl.ex_rn),
    .id_rs_i     (ctl.id_rs),
    .id_rt_i     (ctl.id_rt),
    .id_use_rs_i (ctl.id_use_rs),
    .id_use_rt_i (ctl.id_use_rt),
    .hazard_o    (hazard)
  );

  // Wraps modulo 2^PC_W by truncation.
  assign pc_seq = ctl.pc + PC_W'(PC_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      ld_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    npc_c    = ctl.pc;
    wpcir_c  = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    halted_c = 1'b0;
    case (state_q)
      ST_BOOT: begin
        npc_c    = '0;
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (ctl.mem_busy) begin
          state_d = ST_MEMWAIT;
        end else if (ctl.id_halt) begin
          bubble_c = 1'b1;
          state_d  = ST_HALT;
        end else if (hazard) begin
          // A single-cycle penalty is covered by this RUN cycle alone.
          bubble_c = 1'b1;
          if (LD_STALL > 1) begin
            ld_cnt_d = 2'(LD_STALL - 1);
            state_d  = ST_LDSTALL;
          end
        end else if (ctl.id_br_taken) begin
          npc_c   = ctl.id_target;
          wpcir_c = 1'b1;
          flush_c = 1'b1;
        end else begin
          npc_c   = pc_seq;
          wpcir_c = 1'b1;
        end
      end
      ST_LDSTALL: begin
        bubble_c = 1'b1;
        if (ctl.mem_busy) begin
          ld_cnt_d = 2'd0;
          state_d  = ST_MEMWAIT;
        end else begin
          ld_cnt_d = ld_cnt_q - 2'd1;
          if (ld_cnt_q == 2'd1) state_d = ST_RUN;
        end
      end
      ST_MEMWAIT: begin
        if (!ctl.mem_busy) state_d = ST_RUN;
      end
      ST_HALT: begin
        bubble_c = 1'b1;
        halted_c = 1'b1;
        if (ctl.resume) begin
          // Step past the HALT instruction and discard what sits in IF/ID.
          npc_c   = pc_seq;
          wpcir_c = 1'b1;
          flush_c = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign ctl.npc    = npc_c;
  assign ctl.wpcir  = wpcir_c;
  assign ctl.flush  = flush_c;
  assign ctl.bubble = bubble_c;
  assign ctl.halted = halted_c;

`ifdef PC_SEQ_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != ST_BOOT) && !wpcir_c && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= 16'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign ctl.stall_cnt = stall_cnt_q;
`else
  assign ctl.stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
module tb_pc_seq_ctrl;

  logic clk;
  logic rst_n;

  pc_seq_ctrl_if #(.PC_W(8)) bus ();

  pc_seq_ctrl #(.PC_W(8), .PC_STEP(4), .LD_STALL(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] npc;
    logic       wpcir;
    logic       flush;
    logic       bubble;
    logic       halted;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_npc"},    16'(bus.npc),    16'h00);
    chk({tag, "_wpcir"},  16'(bus.wpcir),  16'h0);
    chk({tag, "_flush"},  16'(bus.flush),  16'h1);
    chk({tag, "_bubble"}, 16'(bus.bubble), 16'h1);
    chk({tag, "_halted"}, 16'(bus.halted), 16'h0);
  endtask

  // Inputs are set at posedge+1; the expected cycle is queued, then popped
  // and compared at the following negedge.
  task automatic step(input string tag, input logic [7:0] e_npc, input logic e_w,
                      input logic e_f, input logic e_b, input logic e_h);
    exp_t e;
    e.tag = tag; e.npc = e_npc; e.wpcir = e_w; e.flush = e_f; e.bubble = e_b; e.halted = e_h;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, "_npc"},    16'(bus.npc),    16'(e.npc));
    chk({e.tag, "_wpcir"},  16'(bus.wpcir),  16'(e.wpcir));
    chk({e.tag, "_flush"},  16'(bus.flush),  16'(e.flush));
    chk({e.tag, "_bubble"}, 16'(bus.bubble), 16'(e.bubble));
    chk({e.tag, "_halted"}, 16'(bus.halted), 16'(e.halted));
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    bus.pc = 8'h00; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
    bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
    bus.ex_m2reg = 1'b0; bus.ex_wreg = 1'b0; bus.ex_rn = 5'd0;
    bus.id_br_taken = 1'b0; bus.id_target = 8'h00;
    bus.id_halt = 1'b0; bus.resume = 1'b0; bus.mem_busy = 1'b0;
  endtask

  logic [15:0] exp_stall4;

  initial begin
`ifdef PC_SEQ_PERF_EN
    exp_stall4 = 16'd4;
`else
    exp_stall4 = 16'd0;
`endif
    rst_n = 1'b0;
    clear_inputs();
    #2;
    chk_reset_outs("por");
    chk("por_stall_cnt", bus.stall_cnt, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    step("boot", 8'h00, 0, 1, 1, 0);
    step("run_seq", 8'h04, 1, 0, 0, 0);

    // load-use on rs, LD_STALL=2: two frozen cycles then sequential
    bus.pc = 8'h04; bus.ex_m2reg = 1; bus.ex_wreg = 1; bus.ex_rn = 5'd5;
    bus.id_rs = 5'd5; bus.id_use_rs = 1;
    step("ld_use0", 8'h04, 0, 0, 1, 0);
    bus.ex_m2reg = 0;
    step("ld_use1", 8'h04, 0, 0, 1, 0);
    step("ld_done", 8'h08, 1, 0, 0, 0);

    // load to r0 never stalls
    bus.pc = 8'h08; bus.ex_m2reg = 1; bus.ex_rn = 5'd0; bus.id_rs = 5'd0;
    step("rn_zero", 8'h0C, 1, 0, 0, 0);
    clear_inputs();

    bus.pc = 8'h0C; bus.id_br_taken = 1; bus.id_target = 8'h40;
    step("br", 8'h40, 1, 1, 0, 0);

    // branch held behind a load-use stall on rt
    bus.pc = 8'h40; bus.id_target = 8'h80;
    bus.ex_m2reg = 1; bus.ex_wreg = 1; bus.ex_rn = 5'd3; bus.id_rt = 5'd3; bus.id_use_rt = 1;
    step("br_haz0", 8'h40, 0, 0, 1, 0);
    bus.ex_m2reg = 0;
    step("br_haz1", 8'h40, 0, 0, 1, 0);
    step("br_after", 8'h80, 1, 1, 0, 0);
    clear_inputs();

    bus.pc = 8'hFC;
    step("wrap", 8'h00, 1, 0, 0, 0);

    // fresh reset so the stall count starts at zero
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_run");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("boot2", 8'h00, 0, 1, 1, 0);

    bus.pc = 8'h10; bus.mem_busy = 1;
    step("mb0", 8'h10, 0, 0, 0, 0);
    step("mb1", 8'h10, 0, 0, 0, 0);
    step("mb2", 8'h10, 0, 0, 0, 0);
    bus.mem_busy = 0;
    step("mb3", 8'h10, 0, 0, 0, 0);
    chk("mb_stall_cnt", bus.stall_cnt, exp_stall4);
    step("mb_done", 8'h14, 1, 0, 0, 0);

    bus.pc = 8'h20; bus.id_halt = 1;
    step("halt_in", 8'h20, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("halt_hold", 8'h20, 0, 0, 1, 1);
    bus.resume = 1;
    step("resume", 8'h24, 1, 1, 1, 1);
    bus.resume = 0; bus.id_halt = 0; bus.pc = 8'h24;
    step("after_res", 8'h28, 1, 0, 0, 0);

    bus.pc = 8'h28; bus.id_halt = 1;
    step("halt2_in", 8'h28, 0, 0, 1, 0);
    step("halt2_hold", 8'h28, 0, 0, 1, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_halt");
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
    step("boot3", 8'h00, 0, 1, 1, 0);
    step("run3", 8'h04, 1, 0, 0, 0);

    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Next-PC and stall controller for the 8-bit pipelined CPU. Each cycle it decides whether the PC register loads (`wpcir`) and what it loads (`npc`). It also squashes or holds the IF/ID stage. It sits between the ID-stage decode/compare logic, the EX-stage destination info, the data-memory busy line and the PC register, and is the only driver of the PC register's write enable and next-PC input.

## Interface
Parameters:
- `PC_W`, 8: PC width in bits.
- `PC_STEP`, 4: sequential PC increment.
- `LD_STALL`, 1: bubble cycles inserted per load-use hazard (1–3).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `pc`  in  PC_W  current PC-register output.
- `id_rs`, `id_rt`  in  5 each  ID source register numbers.
- `id_use_rs`, `id_use_rt`  in  1 each  ID instruction reads rs / rt.
- `ex_m2reg`  in  1  EX instruction is a load.
- `ex_wreg`  in  1  EX instruction writes a register.
- `ex_rn`  in  5  EX destination register.
- `id_br_taken`  in  1  ID branch resolved taken, or jump.
- `id_target`  in  PC_W  branch/jump target.
- `id_halt`  in  1  ID instruction is HALT.
- `resume`  in  1  one-cycle pulse that leaves HALT.
- `mem_busy`  in  1  data memory not ready; the pipeline freezes.
- `npc`  out  PC_W  next PC, to the PC-register data input.
- `wpcir`  out  1  PC and IF/ID write enable.
- `flush`  out  1  load a NOP into IF/ID at the next edge.
- `bubble`  out  1  force ID→EX control signals to zero.
- `halted`  out  1  controller is in HALT.
- `stall_cnt`  out  16  saturating stall-cycle count (PC_SEQ_PERF_EN only).

## Operation
- State register: BOOT, RUN, LDSTALL, MEMWAIT, HALT. A 2-bit down-counter `ld_cnt` is used in LDSTALL.
- Hazard: `ex_m2reg & ex_wreg & (ex_rn != 0) & ((id_use_rs & ex_rn == id_rs) | (id_use_rt & ex_rn == id_rt))`.
- BOOT: `wpcir=0`, `flush=1`, `bubble=1`, `npc=0`. Next state is RUN unconditionally.
- RUN evaluates in priority order:
  1. `mem_busy`: `wpcir=0`, go to MEMWAIT.
  2. `id_halt`: `wpcir=0`, `bubble=1`, go to HALT.
  3. Hazard: `wpcir=0`, `bubble=1`. If `LD_STALL>1`, load `ld_cnt=LD_STALL-1` and go to LDSTALL; otherwise stay in RUN.
  4. `id_br_taken`: `npc=id_target`, `wpcir=1`, `flush=1`.
  5. Otherwise: `npc=pc+PC_STEP`, `wpcir=1`.
- LDSTALL: `wpcir=0`, `bubble=1`, decrement `ld_cnt`. Return to RUN when `ld_cnt==1`. `mem_busy` takes priority: go to MEMWAIT and discard `ld_cnt`.
- MEMWAIT: `wpcir=0`, `bubble=0` (the whole pipe is frozen). Return to RUN in the cycle after `mem_busy` falls.
- HALT: `wpcir=0`, `bubble=1`, `halted=1`. `resume` goes to RUN with `flush=1` and `npc=pc+PC_STEP`, skipping the HALT.
- Whenever `wpcir=0`, `npc` holds `pc` (don't-care to the PC register, but defined for checking).
- Arithmetic is modulo 2^PC_W: `pc=0xFC` with step 4 gives `npc=0x00`. There is no trap.
- A branch held in ID during a stall is re-evaluated when RUN resumes; it is never lost.

## Timing
- The state and `ld_cnt` registers update on the rising edge of `clk`.
- Outputs are combinational from the registered state and same-cycle inputs. There is zero latency from `id_br_taken` to `npc`/`flush`.
- Reset (`rst_n` low, asynchronous): state=BOOT, `ld_cnt=0`, `stall_cnt=0`. Outputs while in reset: `wpcir=0`, `npc=0`, `flush=1`, `bubble=1`, `halted=0`.
- Reset asserted mid-stall or in HALT aborts immediately. After release there is exactly one BOOT cycle, then RUN.
- Load-use penalty is exactly LD_STALL cycles with `wpcir=0`. A taken-branch penalty is one flushed slot.

## Configuration
- `PC_SEQ_PERF_EN` defined: `stall_cnt` increments on every cycle with `wpcir=0` outside BOOT, and saturates at 0xFFFF.
- `PC_SEQ_PERF_EN` undefined: `stall_cnt` is tied to 0 and no counter flops exist.

## Structure
- `pc_seq_pkg` holds the state enum, the PC_W default and the PC_STEP default.
- One sub-module, `pc_seq_hazard`, is combinational load-use detection and is reusable by the forwarding unit.
- The top module holds the FSM, the counters and the next-PC mux.

## Test plan
- Reset release: `pc=0` → one cycle with `wpcir=0`, `flush=1`, then `npc=0x04`, `wpcir=1`.
- Load-use with `ex_rn=5`, `id_rs=5`, `id_use_rs=1`, LD_STALL=2 → two cycles with `wpcir=0`, `bubble=1`, then `npc=pc+4`. With `ex_rn=0` → no stall.
- `id_br_taken=1`, `id_target=0x40` → same cycle `npc=0x40`, `wpcir=1`, `flush=1`. With a simultaneous hazard → stall first, then the branch is taken.
- `mem_busy` high for 3 cycles in RUN → `wpcir=0` for 4 cycles, then resume; `stall_cnt`=4 when PC_SEQ_PERF_EN is defined.
- `id_halt` → `halted=1` and `wpcir=0` indefinitely; a `resume` pulse with `pc=0x20` → `npc=0x24`, `flush=1`.
- `pc=0xFC` sequential → `npc=0x00`. Asserting `rst_n=0` in HALT → `halted=0` immediately.
